ssd_capture: RTL and testbench
==============================

# ssd_capture

Receive-side monitor for the multiplexed seven-segment bus. It samples the active-low cathode and anode lines produced by the display manager and reconstructs the 32-bit hex value being shown, one nibble per digit. It emits a one-cycle strobe when a full 8-digit frame has been captured. It sits on the board-side pins or in the bench loopback path, and is used for self-test and for readback of the value actually on the display.

## Interface
- STABLE, 1000: cycles the {anode, cc} pair must hold unchanged before a digit is sampled. Legal range is 1 to 2^18-1.
- ssd_capture_clk  input  1  system clock; all logic on the rising edge.
- ssd_capture_rst_n  input  1  reset, asynchronous assert, active-low.
- ssd_capture_port_cc  input  7  active-low segment pattern; bit 0 = segment a.
- ssd_capture_port_anode  input  8  active-low digit select; bit n = digit n.
- ssd_capture_oport_value  output  32  last complete frame; digit n occupies bits [4n+3:4n].
- ssd_capture_oport_valid  output  1  one-cycle pulse when value/blank_mask update.
- ssd_capture_oport_blank_mask  output  8  bit n set if digit n's pattern was not a hex glyph in the last frame.
- ssd_capture_oport_error  output  1  one-cycle pulse when a stable, non-one-hot, non-all-high anode is seen.

## Operation
- Inputs pass through the optional synchronizer (see Configuration), then one sample register (prev). The stable counter compares the current sample against prev.
- Stable counter (18 bits): cleared whenever current {anode, cc} differs from prev. Otherwise it increments, saturating at STABLE.
- The sample event fires on the single cycle the counter reaches STABLE. No further sample occurs until the inputs change.
- On a sample event:
  - anode = 8'hFF (blanking) is ignored.
  - A one-hot-low anode gives digit index d.
  - Any other anode pulses error and restarts the frame.
- FSM states: HUNT and COLLECT.
  - HUNT: waits for a sample event with d = 0. It then stores nibble 0, sets expected = 1 and moves to COLLECT.
  - COLLECT: a sample with d = expected stores the nibble and sets expected = expected + 1.
  - COLLECT: a sample with d ≠ expected discards the partial frame. If d = 0 it restarts the frame at digit 0; otherwise it returns to HUNT.
  - COLLECT: when digit 7 is stored, the shadow nibbles and invalid bits transfer to value and blank_mask on the next edge, valid pulses, and the FSM returns to HUNT.
- Decode is the exact inverse of the manager's active-low table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
- Any other cc pattern stores nibble 0 and sets that digit's invalid bit.
- value and blank_mask change only on a valid pulse.

## Timing
- Reset values: value 0, blank_mask 0, valid 0, error 0, FSM in HUNT, counter 0, expected 0.
- Latency from an input change at the pins to the sample event: sync depth (0 or 2) + 1 + STABLE cycles.
- valid and error are asserted for exactly one cycle and never in the same cycle.
- A frame-completion write and a new digit-0 sample can occur in the same cycle. In that case the completion is written and valid pulses, and the new frame starts in COLLECT.
- Reset asserted mid-frame discards the partial frame immediately. value is not retained.
- Each digit must dwell at least STABLE + 1 cycles with no change. Shorter dwells are never sampled, which breaks the digit sequence and causes a restart.

## Configuration
- SSD_CAPTURE_SYNC_EN defined: a two-flop synchronizer is placed on all 15 input bits, adding 2 cycles of latency. Use this when inputs come from pins.
- SSD_CAPTURE_SYNC_EN not defined: inputs feed the sample register directly. Use this for same-clock loopback from the display manager.

## Structure
- Package ssd_pkg holds:
  - SSD_DIGITS = 8.
  - Segment constants SEG_0 … SEG_F and SEG_BLANK = 7'h7F.
  - Anode constants ANODE_NONE = 8'hFF and ANODE_DIGIT[0:7].
  - The FSM state enum {HUNT, COLLECT}.
- Sub-module ssd_segment_decode: combinational, 7-bit pattern in, 4-bit nibble and glyph_ok out, built from the ssd_pkg constants.

## Test plan
- Use STABLE=4 and a 10-cycle dwell per digit. Drive digit 0 to digit 7 with patterns for 3,2,1,0,F,E,D,C, in that order. Required: valid pulses once; value = 32'hCDEF0123; blank_mask = 8'h00.
- Repeat the frame with 2 blanking cycles (anode FF) between digits. Required: the same value; no error pulse.
- Drive digit 5 with cc = 7'b1111111. Required: nibble 5 = 0; blank_mask = 8'h20.
- Drive the sequence 0,1,2,4 (skipping 3), then a clean frame for 32'h12345678. Required: no valid pulse for the broken frame; value = 32'h12345678 after the clean frame.
- Hold anode = 8'b11111100 for 10 cycles. Required: error pulses once; no valid pulse until a fresh digit-0 frame completes.
- Assert rst_n low after digit 4 is stored. Required: all outputs return to 0; the next full frame of 8s gives value = 32'h88888888.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants, FSM state type and anode helper for the seven-segment capture monitor
package ssd_pkg;
  localparam int SSD_DIGITS = 8;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TABLE [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                            SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  localparam logic [7:0] ANODE_NONE = 8'hFF;
  localparam logic [7:0] ANODE_DIGIT [SSD_DIGITS] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                                                      8'hEF, 8'hDF, 8'hBF, 8'h7F};
  typedef enum logic {HUNT, COLLECT} state_t;
  function automatic logic [2:0] anode_index(input logic [7:0] a);
    anode_index = '0;
    for (int i = 0; i < SSD_DIGITS; i++)
      if (a == ANODE_DIGIT[i]) anode_index = 3'(i);
  endfunction
endpackage

// File: rtl/ssd_segment_decode.sv
// ssd_segment_decode: inverse of the active-low hex glyph table; glyph_ok low for any non-hex pattern
module ssd_segment_decode
  import ssd_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       glyph_ok
);
  // table lookup; unmatched patterns decode to nibble 0 with glyph_ok low
  always_comb begin
    nibble = '0;
    glyph_ok = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pattern == SEG_TABLE[i]) begin
        nibble = 4'(i);
        glyph_ok = 1'b1;
      end
  end
endmodule

// File: rtl/ssd_capture.sv
// ssd_capture: rebuilds the 32-bit hex value shown on the multiplexed display; SSD_CAPTURE_SYNC_EN adds a 2-flop input synchronizer
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int STABLE = 1000
) (
  input  logic        ssd_capture_clk,
  input  logic        ssd_capture_rst_n,
  input  logic [6:0]  ssd_capture_port_cc,
  input  logic [7:0]  ssd_capture_port_anode,
  output logic [31:0] ssd_capture_oport_value,
  output logic        ssd_capture_oport_valid,
  output logic [7:0]  ssd_capture_oport_blank_mask,
  output logic        ssd_capture_oport_error
);
  localparam logic [17:0] STB = 18'(STABLE);
  logic [14:0] cur, prev;
  logic [17:0] cnt;
  logic [7:0]  an;
  logic [2:0]  d, expected, exp_nxt;
  logic [3:0]  nib;
  logic        ok, one_hot, sample, store, complete, bad, done;
  logic [31:0] shadow_val;
  logic [7:0]  shadow_inv;
  state_t      state, state_nxt;
`ifdef SSD_CAPTURE_SYNC_EN
  logic [14:0] sync1, sync2;
  // two-flop synchronizer on every bus bit, idles at the blank/all-high level
  always_ff @(posedge ssd_capture_clk or negedge ssd_capture_rst_n)
    if (!ssd_capture_rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {ssd_capture_port_anode, ssd_capture_port_cc};
      sync2 <= sync1;
    end
  assign cur = sync2;
`else
  assign cur = {ssd_capture_port_anode, ssd_capture_port_cc};
`endif
  assign an = cur[14:7];
  assign d = anode_index(an);
  assign one_hot = $onehot(~an);
  assign sample = (cur == prev) && (cnt == STB - 18'd1);
  ssd_segment_decode u_dec (
    .pattern  (cur[6:0]),
    .nibble   (nib),
    .glyph_ok (ok)
  );
  // previous-sample register and saturating stability counter
  always_ff @(posedge ssd_capture_clk or negedge ssd_capture_rst_n)
    if (!ssd_capture_rst_n) begin
      prev <= '1;
      cnt <= '0;
    end else begin
      prev <= cur;
      cnt <= (cur != prev) ? '0 : (cnt == STB) ? cnt : cnt + 18'd1;
    end
  // frame FSM state and expected digit index
  always_ff @(posedge ssd_capture_clk or negedge ssd_capture_rst_n)
    if (!ssd_capture_rst_n) begin
      state <= HUNT;
      expected <= '0;
    end else begin
      state <= state_nxt;
      expected <= exp_nxt;
    end
  // digit sequencing: in-order digits are stored, a stray digit 0 restarts, anything else rehunts
  always_comb begin
    state_nxt = state;
    exp_nxt = expected;
    store = 1'b0;
    complete = 1'b0;
    bad = 1'b0;
    if (sample && an != ANODE_NONE) begin
      if (!one_hot) begin
        bad = 1'b1;
        state_nxt = HUNT;
        exp_nxt = '0;
      end else if (state == COLLECT && d == expected) begin
        store = 1'b1;
        complete = (d == 3'd7);
        state_nxt = complete ? HUNT : COLLECT;
        exp_nxt = complete ? 3'd0 : expected + 3'd1;
      end else if (d == 3'd0) begin
        store = 1'b1;
        state_nxt = COLLECT;
        exp_nxt = 3'd1;
      end else begin
        state_nxt = HUNT;
        exp_nxt = '0;
      end
    end
  end
  // shadow frame capture, one-edge-later publish with valid, error pulse
  always_ff @(posedge ssd_capture_clk or negedge ssd_capture_rst_n)
    if (!ssd_capture_rst_n) begin
      shadow_val <= '0;
      shadow_inv <= '0;
      done <= 1'b0;
      ssd_capture_oport_value <= '0;
      ssd_capture_oport_blank_mask <= '0;
      ssd_capture_oport_valid <= 1'b0;
      ssd_capture_oport_error <= 1'b0;
    end else begin
      if (store) shadow_val[{d, 2'b00} +: 4] <= nib;
      if (store) shadow_inv <= (d == 3'd0) ? {7'd0, ~ok} : shadow_inv | ({7'd0, ~ok} << d);
      done <= complete;
      ssd_capture_oport_valid <= done;
      ssd_capture_oport_error <= bad;
      if (done) begin
        ssd_capture_oport_value <= shadow_val;
        ssd_capture_oport_blank_mask <= shadow_inv;
      end
    end
endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture: directed frames against ssd_capture with STABLE=4
module tb_ssd_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  cc = 7'h7F;
  logic [7:0]  anode = 8'hFF;
  logic [31:0] value;
  logic        valid;
  logic [7:0]  blank_mask;
  logic        error;
  int compared = 0, mismatched = 0;
  int nvalid = 0, nerr = 0, nboth = 0;
  int v0, e0;
  localparam logic [6:0] GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  always #5 clk = ~clk;
  ssd_capture #(.STABLE(4)) dut (
    .ssd_capture_clk              (clk),
    .ssd_capture_rst_n            (rst_n),
    .ssd_capture_port_cc          (cc),
    .ssd_capture_port_anode       (anode),
    .ssd_capture_oport_value      (value),
    .ssd_capture_oport_valid      (valid),
    .ssd_capture_oport_blank_mask (blank_mask),
    .ssd_capture_oport_error      (error)
  );
  always @(negedge clk) begin
    if (valid) nvalid++;
    if (error) nerr++;
    if (valid && error) nboth++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [7:0] a, input logic [6:0] c, input int n);
    anode = a;
    cc = c;
    repeat (n) @(negedge clk);
  endtask
  task automatic digit(input int d, input logic [3:0] n, input int dwell);
    put(8'hFF ^ (8'h01 << d), GLYPH[n], dwell);
  endtask
  task automatic frame(input logic [31:0] v, input int dwell, input int gap, input logic [7:0] bad);
    for (int d = 0; d < 8; d++) begin
      if (bad[d]) put(8'hFF ^ (8'h01 << d), 7'h7F, dwell);
      else digit(d, v[4*d +: 4], dwell);
      if (gap > 0) put(8'hFF, 7'h7F, gap);
    end
    put(8'hFF, 7'h7F, 8);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset value", value, 32'h0);
    check("reset blank", {24'h0, blank_mask}, 32'h0);
    check("reset valid", {31'h0, valid}, 32'h0);
    check("reset error", {31'h0, error}, 32'h0);
    rst_n = 1'b1;
    put(8'hFF, 7'h7F, 4);
    v0 = nvalid; e0 = nerr;
    frame(32'hCDEF0123, 10, 0, 8'h00);
    check("basic value", value, 32'hCDEF0123);
    check("basic blank", {24'h0, blank_mask}, 32'h0);
    check("basic valid count", nvalid - v0, 1);
    check("basic error count", nerr - e0, 0);
    v0 = nvalid; e0 = nerr;
    frame(32'hCDEF0123, 10, 2, 8'h00);
    check("gap value", value, 32'hCDEF0123);
    check("gap valid count", nvalid - v0, 1);
    check("gap error count", nerr - e0, 0);
    v0 = nvalid;
    frame(32'h12345678, 10, 0, 8'h20);
    check("blank value", value, 32'h12045678);
    check("blank mask", {24'h0, blank_mask}, 32'h20);
    check("blank valid count", nvalid - v0, 1);
    v0 = nvalid;
    digit(0, 4'h9, 10); digit(1, 4'h9, 10); digit(2, 4'h9, 10); digit(4, 4'h9, 10);
    put(8'hFF, 7'h7F, 10);
    check("skip no valid", nvalid - v0, 0);
    check("skip value held", value, 32'h12045678);
    check("skip blank held", {24'h0, blank_mask}, 32'h20);
    frame(32'h12345678, 10, 0, 8'h00);
    check("skip clean value", value, 32'h12345678);
    check("skip clean blank", {24'h0, blank_mask}, 32'h0);
    check("skip clean valid", nvalid - v0, 1);
    v0 = nvalid; e0 = nerr;
    put(8'hFC, GLYPH[0], 10);
    put(8'hFF, 7'h7F, 8);
    check("error count", nerr - e0, 1);
    check("error no valid", nvalid - v0, 0);
    check("error value held", value, 32'h12345678);
    frame(32'hA5A5A5A5, 10, 0, 8'h00);
    check("after error value", value, 32'hA5A5A5A5);
    check("after error valid", nvalid - v0, 1);
    v0 = nvalid; e0 = nerr;
    for (int d = 0; d < 4; d++) digit(d, 4'h1, 10);
    put(8'h00, GLYPH[0], 10);
    for (int d = 4; d < 8; d++) digit(d, 4'h1, 10);
    put(8'hFF, 7'h7F, 8);
    check("midframe error count", nerr - e0, 1);
    check("midframe no valid", nvalid - v0, 0);
    check("midframe value held", value, 32'hA5A5A5A5);
    v0 = nvalid;
    frame(32'h76543210, 4, 0, 8'h00);
    check("short dwell no valid", nvalid - v0, 0);
    check("short dwell value held", value, 32'hA5A5A5A5);
    frame(32'h0F1E2D3C, 5, 0, 8'h00);
    check("min dwell valid", nvalid - v0, 1);
    check("min dwell value", value, 32'h0F1E2D3C);
    for (int d = 0; d < 5; d++) digit(d, 4'h8, 10);
    rst_n = 1'b0;
    #1;
    check("midreset value", value, 32'h0);
    check("midreset blank", {24'h0, blank_mask}, 32'h0);
    check("midreset valid", {31'h0, valid}, 32'h0);
    check("midreset error", {31'h0, error}, 32'h0);
    @(negedge clk);
    put(8'hFF, 7'h7F, 2);
    rst_n = 1'b1;
    v0 = nvalid;
    for (int d = 5; d < 8; d++) digit(d, 4'h8, 10);
    put(8'hFF, 7'h7F, 8);
    check("postreset tail no valid", nvalid - v0, 0);
    check("postreset tail value", value, 32'h0);
    frame(32'h88888888, 10, 0, 8'h00);
    check("postreset value", value, 32'h88888888);
    check("postreset valid", nvalid - v0, 1);
    check("valid error overlap", nboth, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
